// File: rtl/fft4_mem_port.sv
// fft4_mem_port: in-place FFT data memory port.
//   Address streams (addr_valid_a/addr_a, addr_valid_b/addr_b) from the even/odd
//   address generators read an operand pair. The pair is returned on
//   rd_valid/rd_data_a/rd_data_b one cycle later, and its addresses are queued.
//   The butterfly result (wb_valid/wb_data_a/wb_data_b) is written back, in
//   order, to the addresses at the queue head.
//   Host port (host_en/host_we/host_addr/host_wdata/host_rdata) loads and
//   unloads memory while the port is idle.
//   Status: busy, done. Sticky errors err_pair/ovf/unf/range/host are cleared
//   by err_clr.
module fft4_mem_port #(
    parameter int AGU_BITWIDTH = 16,
    parameter int DATA_WIDTH   = 32,
    parameter int DEPTH        = 256,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       addr_valid_a,
    input  logic [AGU_BITWIDTH-1:0]    addr_a,
    input  logic                       addr_valid_b,
    input  logic [AGU_BITWIDTH-1:0]    addr_b,
    output logic                       rd_valid,
    output logic [DATA_WIDTH-1:0]      rd_data_a,
    output logic [DATA_WIDTH-1:0]      rd_data_b,
    input  logic                       wb_valid,
    input  logic [DATA_WIDTH-1:0]      wb_data_a,
    input  logic [DATA_WIDTH-1:0]      wb_data_b,
    input  logic                       host_en,
    input  logic                       host_we,
    input  logic [$clog2(DEPTH)-1:0]   host_addr,
    input  logic [DATA_WIDTH-1:0]      host_wdata,
    output logic [DATA_WIDTH-1:0]      host_rdata,
    output logic                       busy,
    output logic                       done,
    input  logic                       err_clr,
    output logic                       err_pair,
    output logic                       err_ovf,
    output logic                       err_unf,
    output logic                       err_range,
    output logic                       err_host
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(FIFO_DEPTH);
    // One bit wider than the address so DEPTH == 2^AGU_BITWIDTH still compares correctly.
    localparam logic [AGU_BITWIDTH:0] DEPTH_W  = (AGU_BITWIDTH+1)'(DEPTH);
    localparam logic [PW:0]           FULL_CNT = (PW+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [AGU_BITWIDTH-1:0] a;
        logic [AGU_BITWIDTH-1:0] b;
    } pair_t;

    logic [DATA_WIDTH-1:0] mem  [DEPTH];
    pair_t                 fifo [FIFO_DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    pair_t         head;
    logic          accept, mismatch, full, empty, push, pop, ovf, unf;
    logic          oor_a, oor_b, head_ok_a, head_ok_b, host_ok, busy_q;

    assign accept    = addr_valid_a & addr_valid_b;
    assign mismatch  = addr_valid_a ^ addr_valid_b;
    assign oor_a     = {1'b0, addr_a} >= DEPTH_W;
    assign oor_b     = {1'b0, addr_b} >= DEPTH_W;

    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign pop       = wb_valid & ~empty;
    assign unf       = wb_valid & empty;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign push      = accept & (~full | pop);
    assign ovf       = accept & full & ~pop;

    assign head      = fifo[rd_ptr];
    assign head_ok_a = {1'b0, head.a} < DEPTH_W;
    assign head_ok_b = {1'b0, head.b} < DEPTH_W;

    assign busy      = (count != '0) | rd_valid;
    assign done      = busy_q & ~busy;
    // Host access never competes with the datapath for the memory.
    assign host_ok   = host_en & ~busy & ~accept & ~wb_valid;

    // Memory array: not reset. Port b is written last, so it wins when head.a == head.b.
    always_ff @(posedge clk) begin
        if (pop) begin
            if (head_ok_a) mem[head.a[AW-1:0]] <= wb_data_a;
            if (head_ok_b) mem[head.b[AW-1:0]] <= wb_data_b;
        end
        if (host_ok & host_we) mem[host_addr] <= host_wdata;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[wr_ptr] <= '{a: addr_a, b: addr_b};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            rd_valid   <= 1'b0;
            rd_data_a  <= '0;
            rd_data_b  <= '0;
            host_rdata <= '0;
            busy_q     <= 1'b0;
            err_pair   <= 1'b0;
            err_ovf    <= 1'b0;
            err_unf    <= 1'b0;
            err_range  <= 1'b0;
            err_host   <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            if (push & ~pop)      count <= count + (PW+1)'(1);
            else if (pop & ~push) count <= count - (PW+1)'(1);

            // Old memory contents are returned: the write above lands at the same edge.
            rd_valid <= accept;
            if (accept) begin
                rd_data_a <= oor_a ? '0 : mem[addr_a[AW-1:0]];
                rd_data_b <= oor_b ? '0 : mem[addr_b[AW-1:0]];
            end

            if (host_ok & ~host_we) host_rdata <= mem[host_addr];

            busy_q <= busy;

            // A fresh error in the clear cycle stays set.
            err_pair  <= (err_pair  & ~err_clr) | mismatch;
            err_ovf   <= (err_ovf   & ~err_clr) | ovf;
            err_unf   <= (err_unf   & ~err_clr) | unf;
            err_range <= (err_range & ~err_clr) | (accept & (oor_a | oor_b));
            err_host  <= (err_host  & ~err_clr) | (host_en & ~host_ok);
        end
    end
endmodule
